dds_sweep: RTL and testbench

Parametrised direct digital synthesiser. Successor to the fixed 22-bit single-tone DDS, with configurable phase, address and sample widths, a lookup-only phase offset, and a linear frequency-sweep (chirp) engine. Sits between the sample-rate pulse generator and the audio/DAC output path. It produces one signed sine sample per accepted sampling pulse, read from a quarter-wave synchronous ROM.

---
 rtl/dds_sweep_if.sv | 31 +++
 rtl/dds_sweep.sv | 153 +++++++++++++++
 tb/tb_dds_sweep.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dds_sweep_if.sv
// rtl/dds_sweep_if.sv - control, tuning and sample bundle for the dds_sweep synthesiser
interface dds_sweep_if #(
  parameter int PHASE_W  = 22,
  parameter int SAMPLE_W = 16
);
  logic                sampling_pulse;
  logic                mode;
  logic [PHASE_W-1:0]  k;
  logic [PHASE_W-1:0]  k_start;
  logic [PHASE_W-1:0]  k_stop;
  logic [PHASE_W-1:0]  k_step;
  logic                sweep_start;
  logic                sweep_repeat;
  logic [PHASE_W-1:0]  phase_offset;
  logic [SAMPLE_W-1:0] sample;
  logic                new_sample_ready;
  logic                sweep_busy;
  logic                sweep_done;

  modport master (
    output sampling_pulse, mode, k, k_start, k_stop, k_step,
           sweep_start, sweep_repeat, phase_offset,
    input  sample, new_sample_ready, sweep_busy, sweep_done
  );

  modport slave (
    input  sampling_pulse, mode, k, k_start, k_stop, k_step,
           sweep_start, sweep_repeat, phase_offset,
    output sample, new_sample_ready, sweep_busy, sweep_done
  );
endinterface

// File: rtl/dds_sweep.sv
// rtl/dds_sweep.sv - quarter-wave DDS with lookup phase offset and linear chirp engine
// Optional phase dither on the lookup path is enabled by defining DDS_SWEEP_DITHER_EN.
module dds_sweep #(
  parameter int PHASE_W  = 22,
  parameter int ADDR_W   = 10,
  parameter int SAMPLE_W = 16
) (
  input logic       clk,
  input logic       reset_n,
  dds_sweep_if.slave bus
);
  localparam real PI        = 3.14159265358979323846;
  localparam int  ROM_DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  function automatic int rom_val(input int i);
    real amp;
    amp = (2.0 ** (SAMPLE_W - 1)) - 1.0;
    return $rtoi(amp * $sin(PI / 2.0 * real'(i) / real'(ROM_DEPTH)) + 0.5);
  endfunction

  logic [SAMPLE_W-1:0] w_rom [ROM_DEPTH];
  for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
    localparam int ROM_V = rom_val(gi);
    assign w_rom[gi] = ROM_V[SAMPLE_W-1:0];
  end

  state_t              r_state;
  logic [PHASE_W-1:0]  r_acc;
  logic [PHASE_W-1:0]  r_k_cur;
  logic [PHASE_W-1:0]  r_p1;
  logic                r_v1;
  logic                r_v2;
  logic                r_h2;
  logic [SAMPLE_W-1:0] r_rom;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_ready;
  logic                r_done;

  logic [PHASE_W-1:0]  w_k_act;
  logic [PHASE_W-1:0]  w_acc_nxt;
  logic [PHASE_W-1:0]  w_p;
  logic [PHASE_W:0]    w_k_nxt;
  logic [ADDR_W-1:0]   w_idx;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_unused_p;

  assign w_k_act   = (bus.mode && (r_state == S_SWEEP || r_state == S_DONE)) ? r_k_cur : bus.k;
  assign w_acc_nxt = r_acc + w_k_act;
  assign w_k_nxt   = {1'b0, r_k_cur} + {1'b0, bus.k_step};

`ifdef DDS_SWEEP_DITHER_EN
  logic [15:0] r_lfsr;

  // Dither only perturbs the lookup phase; the accumulator stays exact.
  assign w_p = w_acc_nxt + bus.phase_offset + PHASE_W'(r_lfsr[PHASE_W-3-ADDR_W:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= 16'hACE1;
    end else if (bus.sampling_pulse) begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end
`else
  assign w_p = w_acc_nxt + bus.phase_offset;
`endif

  // Second quadrant mirrors the table; idx=0 there would need entry 2^ADDR_W, so clamp.
  assign w_idx      = r_p1[PHASE_W-3 -: ADDR_W];
  assign w_addr     = !r_p1[PHASE_W-2] ? w_idx : ((w_idx == '0) ? '1 : -w_idx);
  assign w_unused_p = ^r_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_p1     <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_h2     <= 1'b0;
      r_rom    <= '0;
      r_sample <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_v1 <= bus.sampling_pulse;
      if (bus.sampling_pulse) begin
        r_acc <= w_acc_nxt;
        r_p1  <= w_p;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_rom <= w_rom[w_addr];
        r_h2  <= r_p1[PHASE_W-1];
      end
      r_ready <= r_v2;
      if (r_v2) begin
        r_sample <= r_h2 ? -r_rom : r_rom;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_k_cur <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!bus.mode) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.sweep_start) begin
              r_k_cur <= bus.k_start;
              r_state <= S_SWEEP;
            end
          end
          S_SWEEP: begin
            if (bus.sweep_start) begin
              r_k_cur <= bus.k_start;
            end else if (bus.sampling_pulse) begin
              if (w_k_nxt >= {1'b0, bus.k_stop}) begin
                r_done <= 1'b1;
                if (bus.sweep_repeat) begin
                  r_k_cur <= bus.k_start;
                end else begin
                  r_k_cur <= bus.k_stop;
                  r_state <= S_DONE;
                end
              end else begin
                r_k_cur <= w_k_nxt[PHASE_W-1:0];
              end
            end
          end
          S_DONE: begin
            if (bus.sweep_start) begin
              r_k_cur <= bus.k_start;
              r_state <= S_SWEEP;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.sample           = r_sample;
  assign bus.new_sample_ready = r_ready;
  assign bus.sweep_busy       = (r_state == S_SWEEP);
  assign bus.sweep_done       = r_done;
endmodule

// File: tb/tb_dds_sweep.sv
// tb/tb_dds_sweep.sv - scoreboard bench for dds_sweep against a phase/sine reference model
module tb_dds_sweep;
  localparam int  PW   = 22;
  localparam int  AW   = 10;
  localparam int  SW   = 16;
  localparam longint FULL = 64'd1 << PW;
  localparam longint HALF = 64'd1 << (PW - 1);
  localparam int  Q    = 1 << AW;
  localparam real PI   = 3.14159265358979323846;

  typedef struct {
    int s;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t exp_q[$];

  longint m_acc, m_kc;
  int     m_state;
  bit     e_busy, e_done;

  dds_sweep_if #(.PHASE_W(PW), .SAMPLE_W(SW)) bus ();

  dds_sweep #(.PHASE_W(PW), .ADDR_W(AW), .SAMPLE_W(SW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sine of the lookup phase via half-wave position and quarter-wave mirroring.
  function automatic int ref_sample(input longint p);
    longint u;
    int     a, v;
    u = (p % HALF) >> (PW - 2 - AW);
    a = (u < Q) ? int'(u) : int'(2 * Q - u);
    if (a == Q) a = Q - 1;
    v = $rtoi(32767.0 * $sin(PI / 2.0 * real'(a) / real'(Q)) + 0.5);
    return (p >= HALF) ? -v : v;
  endfunction

  task automatic model(input bit pulse, input bit start);
    longint ka, nxt;
    ka = (bus.mode && m_state != 0) ? m_kc : longint'(bus.k);
    e_done = 1'b0;
    if (pulse) begin
      m_acc = (m_acc + ka) % FULL;
      exp_q.push_back('{ref_sample((m_acc + longint'(bus.phase_offset)) % FULL), cyc + 3});
    end
    if (!bus.mode) begin
      m_state = 0;
    end else if (m_state == 1) begin
      if (start) begin
        m_kc = bus.k_start;
      end else if (pulse) begin
        nxt = m_kc + longint'(bus.k_step);
        if (nxt >= longint'(bus.k_stop)) begin
          e_done = 1'b1;
          if (bus.sweep_repeat) m_kc = bus.k_start;
          else begin
            m_kc = bus.k_stop;
            m_state = 2;
          end
        end else begin
          m_kc = nxt;
        end
      end
    end else if (start) begin
      m_kc = bus.k_start;
      m_state = 1;
    end
    e_busy = (m_state == 1);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit pulse, input bit start);
    bus.sampling_pulse = pulse;
    bus.sweep_start    = start;
    model(pulse, start);
    @(posedge clk);
    #1;
    chk("sweep_busy", bus.sweep_busy, e_busy);
    chk("sweep_done", bus.sweep_done, e_done);
    @(negedge clk);
    bus.sampling_pulse = 1'b0;
    bus.sweep_start    = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_sample", $signed(bus.sample), 0);
    chk("rst_ready", bus.new_sample_ready, 0);
    chk("rst_busy", bus.sweep_busy, 0);
    chk("rst_done", bus.sweep_done, 0);
    exp_q.delete();
    m_acc = 0;
    m_kc = 0;
    m_state = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_sweep(input longint ks, input longint kst, input longint kp, input bit rep);
    bus.mode = 1'b1;
    bus.k_start = PW'(ks);
    bus.k_stop = PW'(kst);
    bus.k_step = PW'(kp);
    bus.sweep_repeat = rep;
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.new_sample_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_ready: got ready=1 expected no pending sample (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sample", $signed(bus.sample), e.s);
        chk("ready_latency", cyc, e.due);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sampling_pulse = 0; bus.mode = 0; bus.k = 0; bus.k_start = 0; bus.k_stop = 0;
    bus.k_step = 0; bus.sweep_start = 0; bus.sweep_repeat = 0; bus.phase_offset = 0;
    m_acc = 0; m_kc = 0; m_state = 0;
    repeat (2) @(negedge clk);
    chk("reset_sample", $signed(bus.sample), 0);
    chk("reset_ready", bus.new_sample_ready, 0);
    chk("reset_busy", bus.sweep_busy, 0);
    chk("reset_done", bus.sweep_done, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fixed tone, quarter-turn step, with and without a quarter-turn lookup offset.
    bus.k = PW'(1 << 20);
    for (int i = 0; i < 8; i++) begin step(1, 0); repeat (3) step(0, 0); end
    bus.phase_offset = PW'(1 << 20);
    for (int i = 0; i < 8; i++) begin step(1, 0); repeat (3) step(0, 0); end
    bus.phase_offset = 0;
    repeat (16) step(1, 0);
    repeat (4) step(0, 0);

    // One-shot sweep, then repeating sweep.
    set_sweep(100, 300, 50, 0);
    step(0, 1);
    for (int i = 0; i < 5; i++) begin step(1, 0); step(0, 0); end
    set_sweep(100, 300, 50, 1);
    step(0, 1);
    repeat (12) step(1, 0);

    // k_start above k_stop, zero step, restart overriding a pulse, mode drop.
    set_sweep(500, 300, 10, 0);
    step(0, 1);
    step(1, 0);
    set_sweep(700, 300000, 0, 0);
    step(0, 1);
    repeat (6) step(1, 0);
    bus.k_step = PW'(40);
    repeat (3) step(1, 0);
    step(1, 1);
    step(1, 0);
    bus.mode = 1'b0;
    step(1, 0);
    step(0, 0);

    // Reset with two samples in flight mid-sweep.
    set_sweep(1000, 90000, 300, 0);
    step(0, 1);
    step(1, 0);
    step(1, 0);
    do_reset();
    repeat (6) step(0, 0);
    bus.mode = 1'b0;
    bus.k = PW'(1 << 20);
    repeat (4) step(1, 0);

    // Randomised tone and sweep traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) begin
        bus.mode = 1'($urandom_range(0, 3) != 0);
        bus.k = PW'($urandom);
        bus.phase_offset = PW'($urandom);
        bus.k_start = PW'($urandom_range(0, 20000));
        bus.k_stop = PW'($urandom_range(0, 40000));
        bus.k_step = PW'($urandom_range(0, 3000));
        bus.sweep_repeat = 1'($urandom_range(0, 1));
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    end

    bus.mode = 1'b0;
    repeat (6) step(0, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
